// File: rtl/trace_ctrl.sv
// trace_ctrl: capture controller feeding the trace buffer.
//
// Samples CPU bus cycles on cpu_stb_i, packs each into a 48-bit trace word and
// enqueues it to the buffer. Sequencing: IDLE -> (arm) ARMED -> (trigger) POST
// -> (post count exhausted) DONE. ARMED keeps enqueueing, so the buffer, which
// overwrites its oldest entry, holds a rolling pre-trigger window.
//
// Optional feature macro: TRACE_DELTA_EN. When defined, tw_o[47:40] carries a
// saturating count of clk cycles since the previous captured sample (or arm).
// When undefined, tw_o[47:40] is 8'h00 and the counter is not built.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   cpu_stb_i, cpu_ab_i,         bus sample strobe, address, data,
//   cpu_db_i, cpu_flags_i        flags {vpb, mlb, sync, rwn}
//   arm_i, stop_i                control pulses
//   trig_ext_i                   external trigger (level, sampled every clk)
//   cfg_trig_addr_i/aen_i        address-match trigger config
//   cfg_post_i                   samples captured after the trigger sample
//   tw_o, twenq_o, tbuf_clear_o  buffer write word / enqueue / clear
//   state_o                      0 IDLE, 1 ARMED, 2 POST, 3 DONE
module trace_ctrl #(
  parameter int unsigned POST_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_stb_i,
  input  logic [23:0]       cpu_ab_i,
  input  logic [7:0]        cpu_db_i,
  input  logic [3:0]        cpu_flags_i,
  input  logic              arm_i,
  input  logic              stop_i,
  input  logic              trig_ext_i,
  input  logic [23:0]       cfg_trig_addr_i,
  input  logic              cfg_trig_aen_i,
  input  logic [POST_W-1:0] cfg_post_i,
  output logic [47:0]       tw_o,
  output logic              twenq_o,
  output logic              tbuf_clear_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StPost  = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [POST_W-1:0]   postcnt_q, postcnt_d;
  logic                pend_q, pend_d;
  logic                enq_d, mark_d, clr_d;
  logic [7:0]          delta;
  logic [47:0]         tw_q;
  logic                twenq_q, clr_q;

  logic trig_hit;
  logic take_trig;

  assign trig_hit  = trig_ext_i |
                     (cpu_stb_i & cfg_trig_aen_i & (cpu_ab_i == cfg_trig_addr_i));
  // A pending ext trigger promotes the next strobe to the trigger sample.
  assign take_trig = cpu_stb_i & (trig_hit | pend_q);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      postcnt_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      postcnt_q <= postcnt_d;
      pend_q    <= pend_d;
    end
  end

  // Next-state logic; priority stop > arm > trigger > strobe.
  always_comb begin
    state_d   = state_q;
    postcnt_d = postcnt_q;
    pend_d    = pend_q;
    if (stop_i) begin
      state_d   = StIdle;
      postcnt_d = '0;
      pend_d    = 1'b0;
    end else if (arm_i) begin
      state_d   = StArmed;
      postcnt_d = cfg_post_i;
      pend_d    = 1'b0;
    end else begin
      unique case (state_q)
        StArmed: begin
          if (take_trig) begin
            pend_d  = 1'b0;
            state_d = (postcnt_q == '0) ? StDone : StPost;
          end else if (!cpu_stb_i && trig_ext_i) begin
            pend_d = 1'b1;
          end
        end
        StPost: begin
          if (cpu_stb_i) begin
            postcnt_d = postcnt_q - 1'b1;
            if (postcnt_d == '0) state_d = StDone;
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode; the strobe in an arm or stop cycle is never captured.
  always_comb begin
    enq_d  = 1'b0;
    mark_d = 1'b0;
    clr_d  = 1'b0;
    if (!stop_i) begin
      if (arm_i) begin
        clr_d = 1'b1;
      end else if (cpu_stb_i && (state_q == StArmed || state_q == StPost)) begin
        enq_d  = 1'b1;
        mark_d = (state_q == StArmed) && take_trig;
      end
    end
  end

`ifdef TRACE_DELTA_EN
  logic [7:0] delta_q;

  // Restarts at 1 so the first sample after arm / capture reads cycles elapsed.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      delta_q <= 8'd0;
    end else if (clr_d || enq_d) begin
      delta_q <= 8'd1;
    end else if (delta_q != 8'hff) begin
      delta_q <= delta_q + 8'd1;
    end
  end

  assign delta = delta_q;
`else
  assign delta = 8'h00;
`endif

  // Registered buffer interface.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tw_q    <= '0;
      twenq_q <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      twenq_q <= enq_d;
      clr_q   <= clr_d;
      if (enq_d) tw_q <= {delta, mark_d, 3'b000, cpu_flags_i, cpu_ab_i, cpu_db_i};
    end
  end

  assign tw_o         = tw_q;
  assign twenq_o      = twenq_q;
  assign tbuf_clear_o = clr_q;
  assign state_o      = state_q;

endmodule
